// File: rtl/gpr_wb_arb.sv
// rtl/gpr_wb_arb.sv - GPR writeback arbiter (EX / LD / DIV) with pending-destination scoreboard
//
// Owns the single write port of gpr_reg and shares it between three
// writeback sources:
//   EX  : in-order pipeline, no handshake, normally always wins
//   LD  : load return, valid/ready handshake
//   DIV : divider result, valid/ready handshake
// LD and DIV are served round-robin. A starvation counter briefly stalls EX
// so a waiting slow source eventually gets the port. A 31-entry scoreboard
// tracks destinations of in-flight long-latency ops and raises hazard_o so
// decode can stall on them.
//
// Parameters
//   STARVE_MAX   consecutive EX wins with a slow source waiting before EX
//                is stalled for one cycle (1..15)
//
// Ports
//   clk, rst_n                         clock, asynchronous active-low reset
//   ex_we_i/ex_waddr_i/ex_wdata_i      EX writeback request
//   ex_stall_o                         EX must hold its writeback this cycle
//   ld_valid_i/ld_ready_o              load result handshake
//   ld_waddr_i/ld_wdata_i              load destination / data
//   div_valid_i/div_ready_o            divider result handshake
//   div_waddr_i/div_wdata_i            divider destination / data
//   iss_valid_i/iss_rd_i               long-latency op issued, its destination
//   dec_rs1_i/dec_rs2_i/dec_rd_i       decode operands and destination
//   hazard_o                           a decode register is pending
//   gpr_we_o/gpr_waddr_o/gpr_wdata_o   registered write port to gpr_reg

module gpr_wb_arb #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        ex_we_i,
    input  logic [4:0]  ex_waddr_i,
    input  logic [31:0] ex_wdata_i,
    output logic        ex_stall_o,

    input  logic        ld_valid_i,
    output logic        ld_ready_o,
    input  logic [4:0]  ld_waddr_i,
    input  logic [31:0] ld_wdata_i,

    input  logic        div_valid_i,
    output logic        div_ready_o,
    input  logic [4:0]  div_waddr_i,
    input  logic [31:0] div_wdata_i,

    input  logic        iss_valid_i,
    input  logic [4:0]  iss_rd_i,

    input  logic [4:0]  dec_rs1_i,
    input  logic [4:0]  dec_rs2_i,
    input  logic [4:0]  dec_rd_i,
    output logic        hazard_o,

    output logic        gpr_we_o,
    output logic [4:0]  gpr_waddr_o,
    output logic [31:0] gpr_wdata_o
);

    // Round-robin pointer encoding: which slow source has priority next.
    localparam logic SRC_LD  = 1'b0;
    localparam logic SRC_DIV = 1'b1;

    // Counter value at which one more EX win (with a slow source waiting)
    // triggers the one-cycle stall.
    localparam logic [3:0] CNT_LAST = 4'(STARVE_MAX - 1);

    logic        rr_ptr;
    logic [3:0]  starve_cnt;
    // Bit 0 is kept for uniform indexing by register number; it is never set.
    logic [31:0] pending;
    logic [31:0] pending_nxt;

    logic        ex_win;
    logic        ld_grant;
    logic        div_grant;
    logic        ld_done;
    logic        div_done;
    logic        slow_valid;
    logic        slow_done;
    logic        stall_trig;

    logic        win_any;
    logic [4:0]  win_waddr;
    logic [31:0] win_wdata;
    logic [4:0]  done_addr;

    // ------------------------------------------------------------------
    // Grant
    // ------------------------------------------------------------------
    always_comb begin
        ex_win    = ex_we_i & ~ex_stall_o;
        ld_grant  = 1'b0;
        div_grant = 1'b0;
        if (!ex_win) begin
            if (rr_ptr == SRC_LD) begin
                if (ld_valid_i) begin
                    ld_grant = 1'b1;
                end else if (div_valid_i) begin
                    div_grant = 1'b1;
                end
            end else begin
                if (div_valid_i) begin
                    div_grant = 1'b1;
                end else if (ld_valid_i) begin
                    ld_grant = 1'b1;
                end
            end
        end
    end

    // The grant logic is purely combinational from inputs, so the readies
    // are gated with rst_n to stay low while the block is held in reset.
    assign ld_ready_o  = ld_grant & rst_n;
    assign div_ready_o = div_grant & rst_n;

    assign ld_done    = ld_valid_i & ld_ready_o;
    assign div_done   = div_valid_i & div_ready_o;
    assign slow_valid = ld_valid_i | div_valid_i;
    assign slow_done  = ld_done | div_done;

    // ------------------------------------------------------------------
    // Winner mux
    // ------------------------------------------------------------------
    always_comb begin
        win_any   = 1'b0;
        win_waddr = 5'd0;
        win_wdata = 32'd0;
        if (ex_win) begin
            win_any   = 1'b1;
            win_waddr = ex_waddr_i;
            win_wdata = ex_wdata_i;
        end else if (ld_grant) begin
            win_any   = 1'b1;
            win_waddr = ld_waddr_i;
            win_wdata = ld_wdata_i;
        end else if (div_grant) begin
            win_any   = 1'b1;
            win_waddr = div_waddr_i;
            win_wdata = div_wdata_i;
        end
    end

    // ------------------------------------------------------------------
    // Output register (latency 1). Address and data only load on a win so
    // a quiet cycle leaves the last value visible; gpr_we_o qualifies it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpr_we_o    <= 1'b0;
            gpr_waddr_o <= 5'd0;
            gpr_wdata_o <= 32'd0;
        end else begin
            gpr_we_o <= win_any & (win_waddr != 5'd0);
            if (win_any) begin
                gpr_waddr_o <= win_waddr;
                gpr_wdata_o <= win_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-robin pointer: after serving a slow source, point at the other
    // one so it has priority on the next contended cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= SRC_LD;
        end else if (ld_done) begin
            rr_ptr <= SRC_DIV;
        end else if (div_done) begin
            rr_ptr <= SRC_LD;
        end
    end

    // ------------------------------------------------------------------
    // Starvation relief. ex_stall_o is registered, so it lands on the cycle
    // after the STARVE_MAX-th consecutive EX win and lasts exactly one cycle
    // (EX cannot win while stalled, so the trigger cannot repeat).
    // ------------------------------------------------------------------
    assign stall_trig = ex_win & slow_valid & (starve_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
            ex_stall_o <= 1'b0;
        end else begin
            ex_stall_o <= stall_trig;
            if (slow_done || !slow_valid || stall_trig) begin
                starve_cnt <= 4'd0;
            end else if (ex_win) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending scoreboard. Clear is applied before set so an issue to the
    // same register in the completion cycle keeps the entry pending (that
    // new op has not returned yet). EX writes never touch it.
    // ------------------------------------------------------------------
    assign done_addr = ld_done ? ld_waddr_i : div_waddr_i;

    always_comb begin
        pending_nxt = pending;
        if (slow_done) begin
            pending_nxt[done_addr] = 1'b0;
        end
        if (iss_valid_i && (iss_rd_i != 5'd0)) begin
            pending_nxt[iss_rd_i] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 32'd0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // An entry clears at the same edge its data is registered onto gpr_*_o,
    // and gpr_reg bypasses its write port, so decode sees no bubble.
    assign hazard_o = pending[dec_rs1_i] | pending[dec_rs2_i] | pending[dec_rd_i];

endmodule

// File: tb/tb_gpr_wb_arb.sv
// tb/tb_gpr_wb_arb.sv - directed table-driven testbench for gpr_wb_arb

module tb_gpr_wb_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_we_i;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        ex_stall_o;
    logic        ld_valid_i;
    logic        ld_ready_o;
    logic [4:0]  ld_waddr_i;
    logic [31:0] ld_wdata_i;
    logic        div_valid_i;
    logic        div_ready_o;
    logic [4:0]  div_waddr_i;
    logic [31:0] div_wdata_i;
    logic        iss_valid_i;
    logic [4:0]  iss_rd_i;
    logic [4:0]  dec_rs1_i;
    logic [4:0]  dec_rs2_i;
    logic [4:0]  dec_rd_i;
    logic        hazard_o;
    logic        gpr_we_o;
    logic [4:0]  gpr_waddr_o;
    logic [31:0] gpr_wdata_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gpr_wb_arb #(.STARVE_MAX(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_we_i     (ex_we_i),
        .ex_waddr_i  (ex_waddr_i),
        .ex_wdata_i  (ex_wdata_i),
        .ex_stall_o  (ex_stall_o),
        .ld_valid_i  (ld_valid_i),
        .ld_ready_o  (ld_ready_o),
        .ld_waddr_i  (ld_waddr_i),
        .ld_wdata_i  (ld_wdata_i),
        .div_valid_i (div_valid_i),
        .div_ready_o (div_ready_o),
        .div_waddr_i (div_waddr_i),
        .div_wdata_i (div_wdata_i),
        .iss_valid_i (iss_valid_i),
        .iss_rd_i    (iss_rd_i),
        .dec_rs1_i   (dec_rs1_i),
        .dec_rs2_i   (dec_rs2_i),
        .dec_rd_i    (dec_rd_i),
        .hazard_o    (hazard_o),
        .gpr_we_o    (gpr_we_o),
        .gpr_waddr_o (gpr_waddr_o),
        .gpr_wdata_o (gpr_wdata_o)
    );

    // exp bits: {ld_ready, div_ready, ex_stall, hazard} in the applied cycle,
    // then gpr_we after the edge. e_a/e_d are checked only when gpr_we is expected.
    typedef struct {
        logic        ex_we;
        logic [4:0]  ex_a;
        logic [31:0] ex_d;
        logic        ld_v;
        logic [4:0]  ld_a;
        logic [31:0] ld_d;
        logic        dv_v;
        logic [4:0]  dv_a;
        logic [31:0] dv_d;
        logic        iss_v;
        logic [4:0]  iss_rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [4:0]  exp;
        logic [4:0]  e_a;
        logic [31:0] e_d;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s step=%0d actual=%h required=%h", name, idx, act, req);
        end
    endtask

    task automatic idle_inputs();
        ex_we_i = 1'b0; ex_waddr_i = 5'd0; ex_wdata_i = 32'd0;
        ld_valid_i = 1'b0; ld_waddr_i = 5'd0; ld_wdata_i = 32'd0;
        div_valid_i = 1'b0; div_waddr_i = 5'd0; div_wdata_i = 32'd0;
        iss_valid_i = 1'b0; iss_rd_i = 5'd0;
        dec_rs1_i = 5'd0; dec_rs2_i = 5'd0; dec_rd_i = 5'd0;
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        ex_we_i = v.ex_we; ex_waddr_i = v.ex_a; ex_wdata_i = v.ex_d;
        ld_valid_i = v.ld_v; ld_waddr_i = v.ld_a; ld_wdata_i = v.ld_d;
        div_valid_i = v.dv_v; div_waddr_i = v.dv_a; div_wdata_i = v.dv_d;
        iss_valid_i = v.iss_v; iss_rd_i = v.iss_rd;
        dec_rs1_i = v.rs1; dec_rs2_i = v.rs2; dec_rd_i = v.rd;
        #1;
        chk("ld_ready", idx, 32'(ld_ready_o), 32'(v.exp[4]));
        chk("div_ready", idx, 32'(div_ready_o), 32'(v.exp[3]));
        chk("ex_stall", idx, 32'(ex_stall_o), 32'(v.exp[2]));
        chk("hazard", idx, 32'(hazard_o), 32'(v.exp[1]));
        @(posedge clk);
        #1;
        chk("gpr_we", idx, 32'(gpr_we_o), 32'(v.exp[0]));
        if (v.exp[0]) begin
            chk("gpr_waddr", idx, 32'(gpr_waddr_o), 32'(v.e_a));
            chk("gpr_wdata", idx, gpr_wdata_o, v.e_d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        // ---------------- vector table ----------------
        // 1: LD only
        vecs.push_back('{1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'b10001, 5'd5, 32'hDEADBEEF});
        // DIV only, brings the round-robin pointer back to LD
        vecs.push_back('{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h11111111, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'b01001, 5'd3, 32'h11111111});
        // 2: both valid: LD first, then DIV
        vecs.push_back('{1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'hA0A0A0A0, 1'b1, 5'd8, 32'hB0B0B0B0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'b10001, 5'd6, 32'hA0A0A0A0});
        vecs.push_back('{1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'hC0C0C0C0, 1'b1, 5'd8, 32'hB0B0B0B0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'b01001, 5'd8, 32'hB0B0B0B0});
        vecs.push_back('{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'b00000, 5'd0, 32'h0});
        // 3: EX every cycle with DIV waiting: 4 EX wins, 1 stall cycle, DIV, EX resumes
        vecs.push_back('{1'b1, 5'd1, 32'hE0000001, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'h12121212, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'b00001, 5'd1, 32'hE0000001});
        vecs.push_back('{1'b1, 5'd2, 32'hE0000002, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'h12121212, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'b00001, 5'd2, 32'hE0000002});
        vecs.push_back('{1'b1, 5'd3, 32'hE0000003, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'h12121212, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'b00001, 5'd3, 32'hE0000003});
        vecs.push_back('{1'b1, 5'd4, 32'hE0000004, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'h12121212, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'b00001, 5'd4, 32'hE0000004});
        vecs.push_back('{1'b1, 5'd5, 32'hE0000005, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'h12121212, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'b01101, 5'd12, 32'h12121212});
        vecs.push_back('{1'b1, 5'd5, 32'hE0000005, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'b00001, 5'd5, 32'hE0000005});
        vecs.push_back('{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'b00000, 5'd0, 32'h0});
        // 4: issue rd=7, decode rs1=7 until the LD to x7 lands
        vecs.push_back('{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd0, 5'd0, 5'b00000, 5'd0, 32'h0});
        vecs.push_back('{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0, 5'd0, 5'b00010, 5'd0, 32'h0});
        vecs.push_back('{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77777777, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0, 5'd0, 5'b10011, 5'd7, 32'h77777777});
        vecs.push_back('{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0, 5'd0, 5'b00000, 5'd0, 32'h0});
        // 5: issue rd=9 and DIV completion to x9 in the same cycle: set wins
        vecs.push_back('{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd0, 5'd0, 5'b00000, 5'd0, 32'h0});
        vecs.push_back('{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99999999, 1'b1, 5'd9, 5'd0, 5'd9, 5'd0, 5'b01011, 5'd9, 32'h99999999});
        vecs.push_back('{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd9, 5'd0, 5'b00010, 5'd0, 32'h0});
        vecs.push_back('{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h90909090, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd9, 5'b10011, 5'd9, 32'h90909090});
        vecs.push_back('{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd9, 5'b00000, 5'd0, 32'h0});
        // DIV to x0: handshake completes, no write
        vecs.push_back('{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0BADF00D, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'b01000, 5'd0, 32'h0});
        // EX beats a waiting LD
        vecs.push_back('{1'b1, 5'd2, 32'h22222222, 1'b1, 5'd11, 32'h00000003, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'b00001, 5'd2, 32'h22222222});
        vecs.push_back('{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'b00000, 5'd0, 32'h0});

        // ---------------- reset state ----------------
        idle_inputs();
        rst_n = 1'b0;
        ld_valid_i = 1'b1;
        ld_waddr_i = 5'd5;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gpr_we", -1, 32'(gpr_we_o), 32'd0);
        chk("rst_gpr_waddr", -1, 32'(gpr_waddr_o), 32'd0);
        chk("rst_gpr_wdata", -1, gpr_wdata_o, 32'd0);
        chk("rst_ex_stall", -1, 32'(ex_stall_o), 32'd0);
        chk("rst_ld_ready", -1, 32'(ld_ready_o), 32'd0);
        chk("rst_hazard", -1, 32'(hazard_o), 32'd0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;

        // ---------------- table ----------------
        foreach (vecs[i]) apply(vecs[i], i);

        // ---------------- 6: reset mid-stream ----------------
        @(negedge clk);
        idle_inputs();
        iss_valid_i = 1'b1; iss_rd_i = 5'd4;
        @(negedge clk);
        iss_rd_i = 5'd20;
        ex_we_i = 1'b1; ex_waddr_i = 5'd15; ex_wdata_i = 32'hF00DF00D;
        @(posedge clk);
        #1;
        chk("pre_rst_gpr_we", 100, 32'(gpr_we_o), 32'd1);
        chk("pre_rst_gpr_wdata", 100, gpr_wdata_o, 32'hF00DF00D);
        @(negedge clk);
        idle_inputs();
        ld_valid_i = 1'b1; ld_waddr_i = 5'd4; ld_wdata_i = 32'h44444444;
        dec_rs1_i = 5'd4; dec_rs2_i = 5'd20;
        #1;
        chk("pre_rst_hazard", 101, 32'(hazard_o), 32'd1);
        chk("pre_rst_ld_ready", 101, 32'(ld_ready_o), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gpr_we", 102, 32'(gpr_we_o), 32'd0);
        chk("mid_rst_gpr_waddr", 102, 32'(gpr_waddr_o), 32'd0);
        chk("mid_rst_gpr_wdata", 102, gpr_wdata_o, 32'd0);
        chk("mid_rst_hazard", 102, 32'(hazard_o), 32'd0);
        chk("mid_rst_ld_ready", 102, 32'(ld_ready_o), 32'd0);
        chk("mid_rst_ex_stall", 102, 32'(ex_stall_o), 32'd0);
        @(posedge clk);
        #1;
        chk("held_rst_ld_ready", 103, 32'(ld_ready_o), 32'd0);
        chk("held_rst_gpr_we", 103, 32'(gpr_we_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dec_rs2_i = 5'd0;
        dec_rd_i = 5'd20;
        #1;
        chk("post_rst_ld_ready", 104, 32'(ld_ready_o), 32'd1);
        chk("post_rst_hazard", 104, 32'(hazard_o), 32'd0);
        @(posedge clk);
        #1;
        chk("post_rst_gpr_we", 105, 32'(gpr_we_o), 32'd1);
        chk("post_rst_gpr_waddr", 105, 32'(gpr_waddr_o), 32'd4);
        chk("post_rst_gpr_wdata", 105, gpr_wdata_o, 32'h44444444);
        @(negedge clk);
        idle_inputs();
        @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
